// File: rtl/axi4lite_reg_subordinate.sv
// rtl/axi4lite_reg_subordinate.sv - AXI4-Lite subordinate exposing NUM_REGS 32-bit control registers
//
// Purpose:
//   Register file for the equalizer (band gains, mode bits) reachable from any
//   AXI4-Lite manager. AW and W may arrive in any order. Byte strobes are honoured.
//   B and R responses are held stable until accepted. Out-of-range indices answer SLVERR.
//   The write and read paths are two independent FSMs.
//
// Ports:
//   S_AXI_ACLK / S_AXI_ARESET      clock, asynchronous active-high reset
//   S_AXI_AW*                      write address channel (index = AWADDR[ADDR_W-1:2])
//   S_AXI_W*                       write data channel with byte strobes
//   S_AXI_B*                       write response channel (00 OKAY, 10 SLVERR)
//   S_AXI_AR*                      read address channel
//   S_AXI_R*                       read data channel (00 OKAY, 10 SLVERR)
//   reg_out                        register i on [32i+31:32i], no latency after commit
//   reg_wr_pulse                   one-cycle pulse per register after an in-range commit
//
// Configuration:
//   AXI_REG_WR_PULSE_EN            when defined, adds the reg_wr_pulse output and its logic

module axi4lite_reg_subordinate #(
  parameter int C_S_AXI_ADDR_WIDTH = 6,
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int NUM_REGS           = 8
) (
  input  logic                                   S_AXI_ACLK,
  input  logic                                   S_AXI_ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]          S_AXI_AWADDR,
  input  logic                                   S_AXI_AWVALID,
  output logic                                   S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]          S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]        S_AXI_WSTRB,
  input  logic                                   S_AXI_WVALID,
  output logic                                   S_AXI_WREADY,
  output logic [1:0]                             S_AXI_BRESP,
  output logic                                   S_AXI_BVALID,
  input  logic                                   S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]          S_AXI_ARADDR,
  input  logic                                   S_AXI_ARVALID,
  output logic                                   S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]          S_AXI_RDATA,
  output logic [1:0]                             S_AXI_RRESP,
  output logic                                   S_AXI_RVALID,
  input  logic                                   S_AXI_RREADY,
  output logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] reg_out
`ifdef AXI_REG_WR_PULSE_EN
  ,
  output logic [NUM_REGS-1:0]                    reg_wr_pulse
`endif
);

  localparam int DW    = C_S_AXI_DATA_WIDTH;
  localparam int SW    = DW / 8;
  localparam int IDX_W = C_S_AXI_ADDR_WIDTH - 2;
  localparam logic [IDX_W:0] NUM_REGS_W = (IDX_W + 1)'(NUM_REGS);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_HAVE_AW, W_HAVE_W, W_RESP} wstate_t;
  typedef enum logic       {R_IDLE, R_DATA} rstate_t;

  wstate_t          wstate_q, wstate_d;
  rstate_t          rstate_q, rstate_d;
  // Holds all READY outputs low during reset. They rise on the first edge after release.
  logic             rdy_q;
  logic [IDX_W-1:0] aw_idx_q, aw_idx_d;
  logic [DW-1:0]    wdata_q, wdata_d;
  logic [SW-1:0]    wstrb_q, wstrb_d;
  logic [1:0]       bresp_q, bresp_d;
  logic [DW-1:0]    rdata_q, rdata_d;
  logic [1:0]       rresp_q, rresp_d;
  logic [DW-1:0]    regs_q [NUM_REGS];
  logic [DW-1:0]    regs_d [NUM_REGS];

  logic             aw_hs, w_hs, ar_hs;
  logic             commit;
  logic [IDX_W-1:0] cm_idx;
  logic [DW-1:0]    cm_data;
  logic [SW-1:0]    cm_strb;
  logic             cm_ok;
  logic [IDX_W-1:0] ar_idx;
  logic [NUM_REGS-1:0] wr_hit;

  // Byte offset bits are ignored by the decode.
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^{S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  function automatic logic in_range(input logic [IDX_W-1:0] idx);
    return {1'b0, idx} < NUM_REGS_W;
  endfunction

  assign S_AXI_AWREADY = rdy_q & ((wstate_q == W_IDLE) | (wstate_q == W_HAVE_W));
  assign S_AXI_WREADY  = rdy_q & ((wstate_q == W_IDLE) | (wstate_q == W_HAVE_AW));
  assign S_AXI_BVALID  = (wstate_q == W_RESP);
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_ARREADY = rdy_q & (rstate_q == R_IDLE);
  assign S_AXI_RVALID  = (rstate_q == R_DATA);
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = rresp_q;

  assign aw_hs = S_AXI_AWVALID & S_AXI_AWREADY;
  assign w_hs  = S_AXI_WVALID  & S_AXI_WREADY;
  assign ar_hs = S_AXI_ARVALID & S_AXI_ARREADY;

  // The commit uses the live channel when its handshake happens on the commit edge.
  // Otherwise it uses the copy captured earlier.
  assign cm_idx  = aw_hs ? S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2] : aw_idx_q;
  assign cm_data = w_hs ? S_AXI_WDATA : wdata_q;
  assign cm_strb = w_hs ? S_AXI_WSTRB : wstrb_q;
  assign cm_ok   = in_range(cm_idx);
  assign ar_idx  = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];

  // Write FSM next state
  always_comb begin
    wstate_d = wstate_q;
    aw_idx_d = aw_idx_q;
    wdata_d  = wdata_q;
    wstrb_d  = wstrb_q;
    bresp_d  = bresp_q;
    commit   = 1'b0;
    if (aw_hs) begin
      aw_idx_d = S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
    end
    if (w_hs) begin
      wdata_d = S_AXI_WDATA;
      wstrb_d = S_AXI_WSTRB;
    end
    case (wstate_q)
      W_IDLE: begin
        if (aw_hs && w_hs) begin
          wstate_d = W_RESP;
          commit   = 1'b1;
        end else if (aw_hs) begin
          wstate_d = W_HAVE_AW;
        end else if (w_hs) begin
          wstate_d = W_HAVE_W;
        end
      end
      W_HAVE_AW: begin
        if (w_hs) begin
          wstate_d = W_RESP;
          commit   = 1'b1;
        end
      end
      W_HAVE_W: begin
        if (aw_hs) begin
          wstate_d = W_RESP;
          commit   = 1'b1;
        end
      end
      W_RESP: begin
        if (S_AXI_BREADY) begin
          wstate_d = W_IDLE;
        end
      end
      default: wstate_d = W_IDLE;
    endcase
    if (commit) begin
      bresp_d = cm_ok ? RESP_OKAY : RESP_SLVERR;
    end
  end

  // Per-register write enables. An all-zero strobe still counts as a hit.
  always_comb begin
    wr_hit = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (commit && cm_ok && (cm_idx == IDX_W'(i))) begin
        wr_hit[i] = 1'b1;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      regs_d[i] = regs_q[i];
      if (wr_hit[i]) begin
        for (int b = 0; b < SW; b++) begin
          if (cm_strb[b]) begin
            regs_d[i][8*b +: 8] = cm_data[8*b +: 8];
          end
        end
      end
    end
  end

  // The read FSM samples regs_q, so a read on the same edge as a commit returns the old value.
  always_comb begin
    rstate_d = rstate_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    case (rstate_q)
      R_IDLE: begin
        if (ar_hs) begin
          rstate_d = R_DATA;
          rresp_d  = in_range(ar_idx) ? RESP_OKAY : RESP_SLVERR;
          rdata_d  = '0;
          for (int i = 0; i < NUM_REGS; i++) begin
            if (ar_idx == IDX_W'(i)) begin
              rdata_d = regs_q[i];
            end
          end
        end
      end
      R_DATA: begin
        if (S_AXI_RREADY) begin
          rstate_d = R_IDLE;
        end
      end
      default: rstate_d = R_IDLE;
    endcase
  end

  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      wstate_q <= W_IDLE;
      rstate_q <= R_IDLE;
      rdy_q    <= 1'b0;
      aw_idx_q <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      bresp_q  <= '0;
      rdata_q  <= '0;
      rresp_q  <= '0;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      wstate_q <= wstate_d;
      rstate_q <= rstate_d;
      rdy_q    <= 1'b1;
      aw_idx_q <= aw_idx_d;
      wdata_q  <= wdata_d;
      wstrb_q  <= wstrb_d;
      bresp_q  <= bresp_d;
      rdata_q  <= rdata_d;
      rresp_q  <= rresp_d;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg_out
    assign reg_out[DW*g +: DW] = regs_q[g];
  end

`ifdef AXI_REG_WR_PULSE_EN
  logic [NUM_REGS-1:0] pulse_q;

  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      pulse_q <= '0;
    end else begin
      pulse_q <= wr_hit;
    end
  end

  assign reg_wr_pulse = pulse_q;
`endif

endmodule

// File: tb/tb_axi4lite_reg_subordinate.sv
// tb/tb_axi4lite_reg_subordinate.sv - self-checking bench for axi4lite_reg_subordinate

module tb_axi4lite_reg_subordinate;

  logic        clk;
  logic        rst;
  logic [5:0]  awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [5:0]  araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [255:0] reg_out;
`ifdef AXI_REG_WR_PULSE_EN
  logic [7:0]  reg_wr_pulse;
`endif

  int checks = 0;
  int failures = 0;

  logic [31:0] model [8];

  axi4lite_reg_subordinate dut (
    .S_AXI_ACLK    (clk),
    .S_AXI_ARESET  (rst),
    .S_AXI_AWADDR  (awaddr),
    .S_AXI_AWVALID (awvalid),
    .S_AXI_AWREADY (awready),
    .S_AXI_WDATA   (wdata),
    .S_AXI_WSTRB   (wstrb),
    .S_AXI_WVALID  (wvalid),
    .S_AXI_WREADY  (wready),
    .S_AXI_BRESP   (bresp),
    .S_AXI_BVALID  (bvalid),
    .S_AXI_BREADY  (bready),
    .S_AXI_ARADDR  (araddr),
    .S_AXI_ARVALID (arvalid),
    .S_AXI_ARREADY (arready),
    .S_AXI_RDATA   (rdata),
    .S_AXI_RRESP   (rresp),
    .S_AXI_RVALID  (rvalid),
    .S_AXI_RREADY  (rready),
    .reg_out       (reg_out)
`ifdef AXI_REG_WR_PULSE_EN
    ,
    .reg_wr_pulse  (reg_wr_pulse)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic bit idx_ok(input logic [5:0] addr);
    return int'(addr[5:2]) < 8;
  endfunction

  function automatic logic [1:0] model_resp(input logic [5:0] addr);
    return idx_ok(addr) ? 2'b00 : 2'b10;
  endfunction

  function automatic logic [31:0] model_read(input logic [5:0] addr);
    return idx_ok(addr) ? model[addr[4:2]] : 32'h0;
  endfunction

  function automatic logic [255:0] model_flat();
    logic [255:0] f;
    for (int i = 0; i < 8; i++) f[32*i +: 32] = model[i];
    return f;
  endfunction

  task automatic model_write(input logic [5:0] addr, input logic [31:0] data, input logic [3:0] strb);
    if (idx_ok(addr)) begin
      for (int b = 0; b < 4; b++) begin
        if (strb[b]) model[addr[4:2]][8*b +: 8] = data[8*b +: 8];
      end
    end
  endtask

  function automatic logic [7:0] model_pulse(input logic [5:0] addr);
    return idx_ok(addr) ? (8'h01 << addr[4:2]) : 8'h00;
  endfunction

  // Starts and ends at posedge+1.
  task automatic do_write(input logic [5:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input int aw_dly, input int w_dly, input int b_dly, output logic [1:0] got);
    int cyc = 0;
    bit aw_done = 0, w_done = 0, af, wf;
    logic [1:0] exp_r;
    awaddr = addr; wdata = data; wstrb = strb;
    while (!(aw_done && w_done)) begin
      if (cyc > 40) begin
        chk("aw_w_handshake_timeout", 0, 1);
        break;
      end
      awvalid = !aw_done && (cyc >= aw_dly);
      wvalid  = !w_done && (cyc >= w_dly);
      @(negedge clk);
      if (w_done && !aw_done) chk("wready_low_waiting_aw", wready, 0);
      if (aw_done && !w_done) chk("awready_low_waiting_w", awready, 0);
      af = awvalid && awready;
      wf = wvalid && wready;
      @(posedge clk); #1;
      aw_done = aw_done | af;
      w_done  = w_done | wf;
      cyc++;
    end
    awvalid = 0; wvalid = 0;
    model_write(addr, data, strb);
    exp_r = model_resp(addr);
    chk("bvalid_after_commit", bvalid, 1);
    chk("reg_out_after_commit", reg_out, model_flat());
`ifdef AXI_REG_WR_PULSE_EN
    chk("wr_pulse_set", reg_wr_pulse, model_pulse(addr));
`endif
    for (int k = 0; k < b_dly; k++) begin
      @(negedge clk);
      chk("bvalid_hold", bvalid, 1);
      chk("bresp_hold", bresp, exp_r);
      chk("aw_w_ready_low_in_resp", {awready, wready}, 2'b00);
      @(posedge clk); #1;
    end
    bready = 1;
    @(negedge clk);
    got = bresp;
    chk("bresp", bresp, exp_r);
    @(posedge clk); #1;
    bready = 0;
`ifdef AXI_REG_WR_PULSE_EN
    chk("wr_pulse_clear", reg_wr_pulse, 8'h00);
`endif
    chk("bvalid_after_b_hs", bvalid, 0);
    chk("ready_after_b_hs", {awready, wready}, 2'b11);
  endtask

  task automatic do_read(input logic [5:0] addr, output logic [31:0] d, output logic [1:0] r);
    int cyc = 0;
    bit f = 0;
    araddr = addr;
    arvalid = 1;
    while (!f) begin
      if (cyc > 20) begin
        chk("ar_handshake_timeout", 0, 1);
        break;
      end
      @(negedge clk);
      f = arready;
      @(posedge clk); #1;
      cyc++;
    end
    arvalid = 0;
    chk("rvalid_after_ar", rvalid, 1);
    chk("arready_low_in_rdata", arready, 0);
    @(negedge clk);
    d = rdata;
    r = rresp;
    rready = 1;
    @(posedge clk); #1;
    rready = 0;
    chk("rvalid_after_r_hs", rvalid, 0);
  endtask

  typedef struct {
    bit          is_wr;
    logic [5:0]  addr;
    logic [31:0] data;
    logic [3:0]  strb;
    int          aw_dly;
    int          w_dly;
    int          b_dly;
    logic [1:0]  exp_resp;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs [15];

  initial begin
    logic [1:0]  gr;
    logic [31:0] gd;
    logic [31:0] old;
    logic [5:0]  ra;
    logic [31:0] rd_;
    logic [3:0]  rs;

    rst = 1;
    awaddr = 0; awvalid = 0; wdata = 0; wstrb = 0; wvalid = 0; bready = 0;
    araddr = 0; arvalid = 0; rready = 0;
    for (int i = 0; i < 8; i++) model[i] = 32'h0;

    vecs[0]  = '{1'b1, 6'h04, 32'hDEADBEEF, 4'hF, 0, 0, 0, 2'b00, 32'h0};
    vecs[1]  = '{1'b0, 6'h04, 32'h0,        4'h0, 0, 0, 0, 2'b00, 32'hDEADBEEF};
    vecs[2]  = '{1'b1, 6'h08, 32'hFFFFFFFF, 4'hF, 0, 0, 0, 2'b00, 32'h0};
    vecs[3]  = '{1'b1, 6'h08, 32'h12345678, 4'h5, 3, 0, 0, 2'b00, 32'h0};
    vecs[4]  = '{1'b0, 6'h08, 32'h0,        4'h0, 0, 0, 0, 2'b00, 32'hFF34FF78};
    vecs[5]  = '{1'b0, 6'h3C, 32'h0,        4'h0, 0, 0, 0, 2'b10, 32'h0};
    vecs[6]  = '{1'b1, 6'h20, 32'hCAFEF00D, 4'hF, 0, 0, 0, 2'b10, 32'h0};
    vecs[7]  = '{1'b0, 6'h20, 32'h0,        4'h0, 0, 0, 0, 2'b10, 32'h0};
    vecs[8]  = '{1'b1, 6'h1D, 32'h11223344, 4'h0, 0, 0, 0, 2'b00, 32'h0};
    vecs[9]  = '{1'b0, 6'h1C, 32'h0,        4'h0, 0, 0, 0, 2'b00, 32'h0};
    vecs[10] = '{1'b1, 6'h1F, 32'hAABBCCDD, 4'hA, 0, 2, 0, 2'b00, 32'h0};
    vecs[11] = '{1'b0, 6'h1E, 32'h0,        4'h0, 0, 0, 0, 2'b00, 32'hAA00CC00};
    vecs[12] = '{1'b1, 6'h0C, 32'h0BADCAFE, 4'hF, 1, 1, 5, 2'b00, 32'h0};
    vecs[13] = '{1'b0, 6'h0C, 32'h0,        4'h0, 0, 0, 0, 2'b00, 32'h0BADCAFE};
    vecs[14] = '{1'b0, 6'h00, 32'h0,        4'h0, 0, 0, 0, 2'b00, 32'h0};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("reset_readys", {awready, wready, arready}, 3'b000);
    chk("reset_valids", {bvalid, rvalid}, 2'b00);
    chk("reset_resp_data", {bresp, rresp, rdata}, 36'h0);
    chk("reset_reg_out", reg_out, 256'h0);
    @(negedge clk);
    rst = 0;
    @(posedge clk); #1;
    chk("readys_after_release", {awready, wready, arready}, 3'b111);

    // Directed table
    for (int v = 0; v < 15; v++) begin
      if (vecs[v].is_wr) begin
        do_write(vecs[v].addr, vecs[v].data, vecs[v].strb,
                 vecs[v].aw_dly, vecs[v].w_dly, vecs[v].b_dly, gr);
        chk($sformatf("vec%0d_bresp", v), gr, vecs[v].exp_resp);
      end else begin
        do_read(vecs[v].addr, gd, gr);
        chk($sformatf("vec%0d_rresp", v), gr, vecs[v].exp_resp);
        chk($sformatf("vec%0d_rdata", v), gd, vecs[v].exp_rdata);
      end
    end

    // A read handshake and a commit to reg 0 on the same edge
    old = model[0];
    awaddr = 6'h00; wdata = 32'h000000A5; wstrb = 4'hF; awvalid = 1; wvalid = 1;
    araddr = 6'h00; arvalid = 1;
    @(posedge clk); #1;
    awvalid = 0; wvalid = 0; arvalid = 0;
    model_write(6'h00, 32'h000000A5, 4'hF);
    chk("same_edge_rvalid", rvalid, 1);
    chk("same_edge_rdata_old", rdata, old);
    chk("same_edge_bvalid", bvalid, 1);
    chk("same_edge_reg_out", reg_out, model_flat());
`ifdef AXI_REG_WR_PULSE_EN
    chk("same_edge_pulse", reg_wr_pulse, 8'h01);
`endif
    bready = 1; rready = 1;
    @(posedge clk); #1;
    bready = 0; rready = 0;
`ifdef AXI_REG_WR_PULSE_EN
    chk("same_edge_pulse_clear", reg_wr_pulse, 8'h00);
`endif
    do_read(6'h00, gd, gr);
    chk("same_edge_next_read", gd, 32'h000000A5);

    // Randomized traffic against the model
    for (int n = 0; n < 40; n++) begin
      ra = 6'($urandom_range(0, 63));
      if ($urandom_range(0, 1) == 1) begin
        rd_ = $urandom;
        rs = 4'($urandom_range(0, 15));
        do_write(ra, rd_, rs, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2), gr);
      end else begin
        do_read(ra, gd, gr);
        chk("rand_rresp", gr, model_resp(ra));
        chk("rand_rdata", gd, model_read(ra));
      end
    end
    chk("rand_reg_out", reg_out, model_flat());

    // Reset while both responses are pending
    awaddr = 6'h14; wdata = 32'h5555AAAA; wstrb = 4'hF; awvalid = 1; wvalid = 1;
    araddr = 6'h04; arvalid = 1;
    @(posedge clk); #1;
    awvalid = 0; wvalid = 0; arvalid = 0;
    chk("pre_reset_valids", {bvalid, rvalid}, 2'b11);
    #2;
    rst = 1;
    #1;
    for (int i = 0; i < 8; i++) model[i] = 32'h0;
    chk("async_reset_valids", {bvalid, rvalid}, 2'b00);
    chk("async_reset_readys", {awready, wready, arready}, 3'b000);
    chk("async_reset_regs", reg_out, model_flat());
    chk("async_reset_resp_data", {bresp, rresp, rdata}, 36'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 0;
    bready = 1; rready = 1;
    @(posedge clk); #1;
    chk("post_reset_readys", {awready, wready, arready}, 3'b111);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk("post_reset_no_response", {bvalid, rvalid}, 2'b00);
    end
    bready = 0; rready = 0;
    do_read(6'h14, gd, gr);
    chk("post_reset_read", gd, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
